// File: rtl/bt_status_tx.sv
// UART transmitter for the Bluetooth module RXD line: sends a latched 32-bit word
// as 8 uppercase ASCII hex characters followed by CR LF, 8N1 framing.
module bt_status_tx #(
    parameter int BAUD_RATE  = 9600,
    parameter int CLOCK_RATE = 100_000_000
) (
    input  logic        clk_tx,
    input  logic        rst_clk_tx,
    input  logic        send_req,
    input  logic [31:0] send_data,
    output logic        send_busy,
    output logic        send_done,
    output logic        txd_tx
);
    localparam int BAUD_DIV = CLOCK_RATE / BAUD_RATE;
    localparam int CNT_W    = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    generate
        if (BAUD_DIV < 2) begin : g_bad_baud_div
            $error("bt_status_tx: CLOCK_RATE/BAUD_RATE must be at least 2");
        end
    endgenerate

    logic [1:0]       r_state;
    logic [31:0]      r_word;
    logic [3:0]       r_idx;
    logic [2:0]       r_bit;
    logic [CNT_W-1:0] r_baud;
    logic             r_txd;
    logic             r_busy;
    logic             r_done;

    logic [3:0]       w_nibble;
    logic [7:0]       w_char;
    logic [2:0]       w_bit_next;
    logic             w_baud_end;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Character 0..7 are hex digits MSB nibble first, then CR, LF.
    always_comb begin
        w_nibble = r_word[5'd28 - {r_idx[2:0], 2'b00} +: 4];
        if (r_idx == 4'd8)
            w_char = 8'h0D;
        else if (r_idx == 4'd9)
            w_char = 8'h0A;
        else
            w_char = hex_ascii(w_nibble);
    end

    assign w_bit_next = r_bit + 3'd1;
    assign w_baud_end = (r_baud == BAUD_LAST);

    always_ff @(posedge clk_tx or posedge rst_clk_tx) begin
        if (rst_clk_tx) begin
            r_state <= S_IDLE;
            r_word  <= 32'h0;
            r_idx   <= 4'd0;
            r_bit   <= 3'd0;
            r_baud  <= '0;
            r_txd   <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (send_req) begin
                        r_word  <= send_data;
                        r_idx   <= 4'd0;
                        r_bit   <= 3'd0;
                        r_baud  <= '0;
                        r_txd   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_bit   <= 3'd0;
                        r_txd   <= w_char[0];
                        r_state <= S_DATA;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (r_bit == 3'd7) begin
                            r_txd   <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_bit <= w_bit_next;
                            r_txd <= w_char[w_bit_next];
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        // Last character: release busy together with the done pulse.
                        if (r_idx == 4'd9) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_idx   <= r_idx + 4'd1;
                            r_txd   <= 1'b0;
                            r_state <= S_START;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign send_busy = r_busy;
    assign send_done = r_done;
    assign txd_tx    = r_txd;

endmodule

// File: tb/tb_bt_status_tx.sv
// Directed testbench for bt_status_tx at BAUD_DIV=16 (CLOCK_RATE=160, BAUD_RATE=10);
// decodes the serial line by mid-bit sampling on the falling clock edge.
module tb_bt_status_tx;
    logic        clk = 1'b0;
    logic        rst_clk_tx = 1'b1;
    logic        send_req = 1'b0;
    logic [31:0] send_data = 32'h0;
    logic        send_busy;
    logic        send_done;
    logic        txd_tx;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] rx_bytes [10];
    int  busy_cnt, done_cnt, done_n, done_cyc, frame_err, gap_wait;
    bit  got_msg;
    int  edge_q [$];

    bt_status_tx #(.BAUD_RATE(10), .CLOCK_RATE(160)) dut (
        .clk_tx     (clk),
        .rst_clk_tx (rst_clk_tx),
        .send_req   (send_req),
        .send_data  (send_data),
        .send_busy  (send_busy),
        .send_done  (send_done),
        .txd_tx     (txd_tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // Called on a falling edge; leaves the bench on the falling edge after acceptance.
    task automatic pulse_req(input logic [31:0] d);
        send_data = d;
        send_req  = 1'b1;
        @(negedge clk);
        send_req  = 1'b0;
    endtask

    task automatic wait_start(input int limit);
        gap_wait = 0;
        while (txd_tx !== 1'b0 && gap_wait < limit) begin
            @(negedge clk);
            gap_wait++;
        end
        got_msg = (txd_tx === 1'b0);
    endtask

    task automatic recv_msg(input int limit);
        logic prev;
        int c, k;
        busy_cnt = 0; done_cnt = 0; done_n = -1; done_cyc = -1; frame_err = 0;
        edge_q.delete();
        foreach (rx_bytes[i]) rx_bytes[i] = 8'h00;
        wait_start(limit);
        if (!got_msg) return;
        prev = 1'b1;
        for (int n = 0; n <= 1600; n++) begin
            if (n > 0) @(negedge clk);
            if (txd_tx !== prev) begin
                edge_q.push_back(n);
                prev = txd_tx;
            end
            if (send_busy === 1'b1) busy_cnt++;
            if (send_done === 1'b1) begin
                done_cnt++;
                done_n   = n;
                done_cyc = cyc;
            end
            if (n < 1600 && (n % 16) == 8) begin
                c = n / 160;
                k = (n % 160) / 16;
                if (k == 0) begin
                    if (txd_tx !== 1'b0) frame_err++;
                end else if (k == 9) begin
                    if (txd_tx !== 1'b1) frame_err++;
                end else begin
                    rx_bytes[c][k-1] = txd_tx;
                end
            end
        end
    endtask

    task automatic test_reset();
        int bad_txd, bad_busy, bad_done;
        repeat (5) @(negedge clk);
        n_assert++;
        if ({txd_tx, send_busy, send_done} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_hold: txd/busy/done=%b expected 100", {txd_tx, send_busy, send_done});
        end
        rst_clk_tx = 1'b0;
        bad_txd = 0; bad_busy = 0; bad_done = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (txd_tx !== 1'b1)    bad_txd++;
            if (send_busy !== 1'b0) bad_busy++;
            if (send_done !== 1'b0) bad_done++;
        end
        n_assert++;
        if (bad_txd != 0) begin n_fail++; $display("FAIL idle_txd: %0d non-high cycles, expected 0", bad_txd); end
        n_assert++;
        if (bad_busy != 0) begin n_fail++; $display("FAIL idle_busy: %0d busy cycles, expected 0", bad_busy); end
        n_assert++;
        if (bad_done != 0) begin n_fail++; $display("FAIL idle_done: %0d done cycles, expected 0", bad_done); end
    endtask

    task automatic test_single();
        logic [7:0] exp [10];
        exp = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h41, 8'h42, 8'h43, 8'h44, 8'h0D, 8'h0A};
        pulse_req(32'h1234ABCD);
        n_assert++;
        if (txd_tx !== 1'b0) begin n_fail++; $display("FAIL single_start_latency: txd=%b expected 0", txd_tx); end
        recv_msg(4);
        n_assert++;
        if (!got_msg || gap_wait != 0) begin n_fail++; $display("FAIL single_start: got=%0d wait=%0d expected 1/0", got_msg, gap_wait); end
        for (int i = 0; i < 10; i++) begin
            n_assert++;
            if (rx_bytes[i] !== exp[i]) begin
                n_fail++;
                $display("FAIL single_byte%0d: got %h expected %h", i, rx_bytes[i], exp[i]);
            end
        end
        n_assert++;
        if (frame_err != 0) begin n_fail++; $display("FAIL single_framing: %0d bad start/stop, expected 0", frame_err); end
        n_assert++;
        if (done_cnt != 1 || done_n != 1600) begin n_fail++; $display("FAIL single_done: count=%0d at=%0d expected 1 at 1600", done_cnt, done_n); end
        n_assert++;
        if (busy_cnt != 1600) begin n_fail++; $display("FAIL single_busy_len: %0d expected 1600", busy_cnt); end
        wait_start(50);
        n_assert++;
        if (got_msg) begin n_fail++; $display("FAIL single_extra: unexpected start bit, expected idle"); end
    endtask

    task automatic test_busy_ignore();
        pulse_req(32'h00000000);
        fork
            recv_msg(4);
            begin
                repeat (299) @(negedge clk);
                pulse_req(32'hFFFFFFFF);
            end
        join
        for (int i = 0; i < 8; i++) begin
            n_assert++;
            if (rx_bytes[i] !== 8'h30) begin
                n_fail++;
                $display("FAIL busy_byte%0d: got %h expected 30", i, rx_bytes[i]);
            end
        end
        n_assert++;
        if (rx_bytes[8] !== 8'h0D || rx_bytes[9] !== 8'h0A) begin
            n_fail++;
            $display("FAIL busy_crlf: got %h %h expected 0d 0a", rx_bytes[8], rx_bytes[9]);
        end
        n_assert++;
        if (done_cnt != 1) begin n_fail++; $display("FAIL busy_done: count=%0d expected 1", done_cnt); end
        wait_start(400);
        n_assert++;
        if (got_msg) begin n_fail++; $display("FAIL busy_second_msg: second start bit seen, expected none"); end
    endtask

    task automatic test_back_to_back();
        int d1, gap2;
        logic [7:0] exp [10];
        exp = '{8'h30, 8'h46, 8'h30, 8'h46, 8'h30, 8'h46, 8'h30, 8'h46, 8'h0D, 8'h0A};
        send_data = 32'h0F0F0F0F;
        send_req  = 1'b1;
        @(negedge clk);
        recv_msg(4);
        d1 = done_cyc;
        for (int i = 0; i < 10; i++) begin
            n_assert++;
            if (rx_bytes[i] !== exp[i]) begin
                n_fail++;
                $display("FAIL b2b_msg1_byte%0d: got %h expected %h", i, rx_bytes[i], exp[i]);
            end
        end
        recv_msg(4);
        send_req = 1'b0;
        gap2 = gap_wait;
        n_assert++;
        if (!got_msg || gap2 != 1) begin n_fail++; $display("FAIL b2b_gap: got=%0d idle cycles=%0d expected 1/1", got_msg, gap2); end
        for (int i = 0; i < 10; i++) begin
            n_assert++;
            if (rx_bytes[i] !== exp[i]) begin
                n_fail++;
                $display("FAIL b2b_msg2_byte%0d: got %h expected %h", i, rx_bytes[i], exp[i]);
            end
        end
        n_assert++;
        if (done_cnt != 1 || done_cyc - d1 != 1601) begin
            n_fail++;
            $display("FAIL b2b_done_spacing: count=%0d spacing=%0d expected 1/1601", done_cnt, done_cyc - d1);
        end
        wait_start(100);
        n_assert++;
        if (got_msg) begin n_fail++; $display("FAIL b2b_third_msg: third start bit seen, expected none"); end
    endtask

    task automatic test_reset_mid();
        int bad;
        logic [7:0] exp [10];
        exp = '{8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};
        pulse_req(32'h12345678);
        repeat (501) @(negedge clk);
        n_assert++;
        if (txd_tx !== 1'b0 || send_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_pre: txd=%b busy=%b expected 0/1", txd_tx, send_busy);
        end
        rst_clk_tx = 1'b1;
        #1;
        n_assert++;
        if ({txd_tx, send_busy, send_done} !== 3'b100) begin
            n_fail++;
            $display("FAIL mid_async_reset: txd/busy/done=%b expected 100", {txd_tx, send_busy, send_done});
        end
        bad = 0;
        repeat (3) @(negedge clk);
        rst_clk_tx = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (send_done !== 1'b0 || txd_tx !== 1'b1 || send_busy !== 1'b0) bad++;
        end
        n_assert++;
        if (bad != 0) begin n_fail++; $display("FAIL mid_after_reset: %0d non-idle cycles, expected 0", bad); end
        pulse_req(32'hDEADBEEF);
        recv_msg(4);
        for (int i = 0; i < 10; i++) begin
            n_assert++;
            if (rx_bytes[i] !== exp[i]) begin
                n_fail++;
                $display("FAIL mid_byte%0d: got %h expected %h", i, rx_bytes[i], exp[i]);
            end
        end
        n_assert++;
        if (done_cnt != 1 || done_n != 1600 || frame_err != 0) begin
            n_fail++;
            $display("FAIL mid_done: count=%0d at=%0d framing=%0d expected 1/1600/0", done_cnt, done_n, frame_err);
        end
    endtask

    task automatic test_bit_period();
        int e [$];
        int exp_w [6];
        exp_w = '{16, 16, 48, 32, 32, 16};
        pulse_req(32'h00000001);
        recv_msg(4);
        n_assert++;
        if (rx_bytes[7] !== 8'h31) begin n_fail++; $display("FAIL period_char: got %h expected 31", rx_bytes[7]); end
        foreach (edge_q[i])
            if (edge_q[i] >= 1120 && edge_q[i] <= 1280) e.push_back(edge_q[i]);
        n_assert++;
        if (e.size() != 7 || e[0] != 1120) begin
            n_fail++;
            $display("FAIL period_edges: %0d edges first=%0d expected 7 first=1120", e.size(), (e.size() > 0) ? e[0] : -1);
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_assert++;
                if (e[i+1] - e[i] != exp_w[i]) begin
                    n_fail++;
                    $display("FAIL period_width%0d: %0d cycles expected %0d", i, e[i+1] - e[i], exp_w[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        test_bit_period();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
